// File: rtl/mdio_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_responder_pkg
//  Purpose  : Shared constants, field widths and FSM encoding for the MDIO
//             responder (PHY side of the management link).
//  Revision : 1.0  initial release
// ============================================================================
package mdio_responder_pkg;

    // Frame field codes (MSB first on the wire)
    localparam logic [1:0] ST_CODE = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    // Field widths
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 32;
    localparam int CNT_W   = 5;

    // Counter reload values. A field of N bits loads N-1 and finishes on the
    // rise where the counter is already zero. Skip counts cover every bit
    // left up to and including bit 32 so that DATA content can never be
    // mistaken for a new start-of-frame.
    localparam logic [CNT_W-1:0] C_OP_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PHY_LAST  = CNT_W'(PHYAD_W - 1);
    localparam logic [CNT_W-1:0] C_REG_LAST  = CNT_W'(REGAD_W - 1);
    localparam logic [CNT_W-1:0] C_TA_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_SKIP_OP   = CNT_W'(FRAME_W - 4 - 1);   // bits 5..32
    localparam logic [CNT_W-1:0] C_SKIP_PHY  = CNT_W'(FRAME_W - 9 - 1);   // bits 10..32
    localparam logic [CNT_W-1:0] C_SKIP_TA   = CNT_W'(FRAME_W - 16 - 1);  // bits 17..32
    // Rises seen while serving a read: bit 15 (TA) through bit 32
    localparam logic [CNT_W-1:0] C_RD_RISES  = CNT_W'(FRAME_W - 14);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ST1   = 4'd1,
        S_OP    = 4'd2,
        S_PHY   = 4'd3,
        S_REG   = 4'd4,
        S_TA    = 4'd5,
        S_WDATA = 4'd6,
        S_RDATA = 4'd7,
        S_SKIP  = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdio_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_responder_if
//  Purpose  : MDIO line plus register-file side band of the responder.
//  Ports    : master = station/verification side (drives MDC, MDIO_IN,
//             DBG_ADDR); slave = responder (drives line and strobes).
//  Revision : 1.0  initial release
// ============================================================================
interface mdio_responder_if;
    import mdio_responder_pkg::*;

    logic               MDC;
    logic               MDIO_IN;
    logic               MDIO_OUT;
    logic               MDIO_OE;
    logic               WR_STB;
    logic [REGAD_W-1:0] WR_ADDR;
    logic [DATA_W-1:0]  WR_DATA;
    logic               RD_STB;
    logic               FRAME_ERR;
    logic [REGAD_W-1:0] DBG_ADDR;
    logic [DATA_W-1:0]  DBG_DATA;

    modport master (
        output MDC, MDIO_IN, DBG_ADDR,
        input  MDIO_OUT, MDIO_OE, WR_STB, WR_ADDR, WR_DATA,
               RD_STB, FRAME_ERR, DBG_DATA
    );

    modport slave (
        input  MDC, MDIO_IN, DBG_ADDR,
        output MDIO_OUT, MDIO_OE, WR_STB, WR_ADDR, WR_DATA,
               RD_STB, FRAME_ERR, DBG_DATA
    );

endinterface
`default_nettype wire

// File: rtl/mdio_responder_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_responder_regfile
//  Purpose  : 32 x 16 management register file. One synchronous write port,
//             two asynchronous read ports (frame read, debug read).
//  Ports    : clk, rst (async, active high), i_we/i_waddr/i_wdata,
//             i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b
//  Revision : 1.0  initial release
// ============================================================================
module mdio_responder_regfile
    import mdio_responder_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_we,
    input  wire logic [REGAD_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0]  i_wdata,
    input  wire logic [REGAD_W-1:0] i_raddr_a,
    output      logic [DATA_W-1:0]  o_rdata_a,
    input  wire logic [REGAD_W-1:0] i_raddr_b,
    output      logic [DATA_W-1:0]  o_rdata_b
);

    localparam int c_DEPTH = 2 ** REGAD_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_responder
//  Purpose  : PHY-side MDIO responder. Samples MDIO_IN on MDC rising edges,
//             decodes ST/OP/PHYAD/REGAD/TA/DATA, writes the register file on
//             write frames and drives TA + 16 data bits on read frames.
//             Line outputs change only on MDC falling edges.
//  Ports    : clk, RESET (async, active high), bus (mdio_responder_if.slave)
//  Revision : 1.0  initial release
// ============================================================================
module mdio_responder
    import mdio_responder_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR    = 5'd1,
    parameter int                 MIN_MDC_DIV = 4
)(
    input  wire logic       clk,
    input  wire logic       RESET,
    mdio_responder_if.slave bus
);

    // ------------------------------------------------------------------
    // MDC edge detection
    // ------------------------------------------------------------------
    logic r_mdc_d;
    logic w_rise;
    logic w_fall;

    assign w_rise = bus.MDC & ~r_mdc_d;
    assign w_fall = ~bus.MDC & r_mdc_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic [DATA_W-1:0]  r_shift,    w_shift_nxt;
    logic [1:0]         r_op,       w_op_nxt;
    logic [REGAD_W-1:0] r_reg,      w_reg_nxt;
    logic               r_out,      w_out_nxt;
    logic               r_oe,       w_oe_nxt;
    logic               r_wr_stb,   w_wr_stb_nxt;
    logic [REGAD_W-1:0] r_wr_addr,  w_wr_addr_nxt;
    logic [DATA_W-1:0]  r_wr_data,  w_wr_data_nxt;
    logic               r_rd_stb,   w_rd_stb_nxt;
    logic               r_ferr,     w_ferr_nxt;

    // Shift register with the bit being sampled this cycle appended; the
    // low bits of this word are the value of whichever field just ended.
    logic [DATA_W-1:0]  w_shifted;
    logic               w_rf_we;
    logic [DATA_W-1:0]  w_rf_rdata;

    assign w_shifted = {r_shift[DATA_W-2:0], bus.MDIO_IN};

    mdio_responder_regfile u_regfile (
        .clk       (clk),
        .rst       (RESET),
        .i_we      (w_rf_we),
        .i_waddr   (r_reg),
        .i_wdata   (w_shifted),
        .i_raddr_a (w_shifted[REGAD_W-1:0]),
        .o_rdata_a (w_rf_rdata),
        .i_raddr_b (bus.DBG_ADDR),
        .o_rdata_b (bus.DBG_DATA)
    );

    // ------------------------------------------------------------------
    // Sequential process
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_mdc_d   <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_op      <= '0;
            r_reg     <= '0;
            r_out     <= 1'b0;
            r_oe      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_stb  <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_mdc_d   <= bus.MDC;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_op      <= w_op_nxt;
            r_reg     <= w_reg_nxt;
            r_out     <= w_out_nxt;
            r_oe      <= w_oe_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rd_stb  <= w_rd_stb_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_op_nxt      = r_op;
        w_reg_nxt     = r_reg;
        w_out_nxt     = r_out;
        w_oe_nxt      = r_oe;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_wr_stb_nxt  = 1'b0;
        w_rd_stb_nxt  = 1'b0;
        w_ferr_nxt    = 1'b0;
        w_rf_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Preamble 1s keep us here; the first 0 is ST bit 1.
                if (w_rise && (bus.MDIO_IN == ST_CODE[1])) begin
                    w_state_nxt = S_ST1;
                end
            end

            S_ST1: begin
                if (w_rise) begin
                    if (bus.MDIO_IN == ST_CODE[0]) begin
                        w_state_nxt = S_OP;
                        w_cnt_nxt   = C_OP_LAST;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_OP: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_op_nxt = w_shifted[1:0];
                        if ((w_shifted[1:0] == OP_WR) || (w_shifted[1:0] == OP_RD)) begin
                            w_state_nxt = S_PHY;
                            w_cnt_nxt   = C_PHY_LAST;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_SKIP;
                            w_cnt_nxt   = C_SKIP_OP;
                        end
                    end
                end
            end

            S_PHY: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        if (w_shifted[PHYAD_W-1:0] == PHY_ADDR) begin
                            w_state_nxt = S_REG;
                            w_cnt_nxt   = C_REG_LAST;
                        end else begin
                            // Frame for another PHY: stay silent to the end.
                            w_state_nxt = S_SKIP;
                            w_cnt_nxt   = C_SKIP_PHY;
                        end
                    end
                end
            end

            S_REG: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_reg_nxt = w_shifted[REGAD_W-1:0];
                        if (r_op == OP_WR) begin
                            w_state_nxt = S_TA;
                            w_cnt_nxt   = C_TA_LAST;
                        end else begin
                            // Snapshot read data now; the shift register
                            // then serves as the output shifter.
                            w_state_nxt = S_RDATA;
                            w_cnt_nxt   = '0;
                            w_shift_nxt = w_rf_rdata;
                        end
                    end
                end
            end

            S_TA: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        if (w_shifted[1:0] == TA_WR) begin
                            w_state_nxt = S_WDATA;
                            w_cnt_nxt   = C_DATA_LAST;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_SKIP;
                            w_cnt_nxt   = C_SKIP_TA;
                        end
                    end
                end
            end

            S_WDATA: begin
                if (w_rise) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_rf_we       = 1'b1;
                        w_wr_addr_nxt = r_reg;
                        w_wr_data_nxt = w_shifted;
                        w_wr_stb_nxt  = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end

            S_RDATA: begin
                // r_cnt counts rises from bit 15; each following fall acts
                // on that count. The fall after bit 14 sees 0 and is ignored.
                if (w_rise) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (w_fall) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_oe_nxt  = 1'b1;
                        w_out_nxt = 1'b0;
                    end else if (r_cnt == C_RD_RISES) begin
                        w_oe_nxt     = 1'b0;
                        w_out_nxt    = 1'b0;
                        w_rd_stb_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else if (r_cnt >= CNT_W'(2)) begin
                        w_out_nxt   = r_shift[DATA_W-1];
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end

            S_SKIP: begin
                if (w_rise) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.MDIO_OUT  = r_out;
    assign bus.MDIO_OE   = r_oe;
    assign bus.WR_STB    = r_wr_stb;
    assign bus.WR_ADDR   = r_wr_addr;
    assign bus.WR_DATA   = r_wr_data;
    assign bus.RD_STB    = r_rd_stb;
    assign bus.FRAME_ERR = r_ferr;

    // ------------------------------------------------------------------
    // MDC rate check: consecutive MDC edges must be at least half an MDC
    // period of MIN_MDC_DIV clocks apart, otherwise edges can be missed.
    // ------------------------------------------------------------------
    localparam int c_GAP_MIN = (MIN_MDC_DIV / 2) - 1;

    logic [7:0] r_gap;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_gap <= '1;
        end else if (w_rise || w_fall) begin
            r_gap <= '0;
        end else if (r_gap != '1) begin
            r_gap <= r_gap + 8'd1;
        end
    end

    a_mdc_rate: assert property (@(posedge clk) disable iff (RESET)
        (w_rise || w_fall) |-> (int'(r_gap) >= c_GAP_MIN));

endmodule
`default_nettype wire
